// File: rtl/core_sim_monitor_pkg.sv
// Shared definitions for the core simulation monitor: FSM encoding,
// default end-of-program marker and the hardwired-zero register index.
package core_sim_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Default end-of-program marker: the program writes END_VAL to END_REG.
  localparam int DEF_END_REG = 26;
  localparam int DEF_END_VAL = 1;

  // x0 is hardwired zero; writes to it are never tracked or counted.
  localparam int X0_IDX = 0;

endpackage

// File: rtl/core_sim_monitor_if.sv
// Snoop bus into the monitor: core write-back port plus the
// expected-value table programming port.
interface core_sim_monitor_if #(
  parameter int AW   = 5,
  parameter int XLEN = 32
);
  logic            wb_we_i;
  logic [AW-1:0]   wb_waddr_i;
  logic [XLEN-1:0] wb_wdata_i;
  logic            exp_we_i;
  logic [AW-1:0]   exp_addr_i;
  logic [XLEN-1:0] exp_data_i;
  logic            exp_vld_i;

  modport master (
    output wb_we_i, wb_waddr_i, wb_wdata_i,
    output exp_we_i, exp_addr_i, exp_data_i, exp_vld_i
  );

  modport slave (
    input wb_we_i, wb_waddr_i, wb_wdata_i,
    input exp_we_i, exp_addr_i, exp_data_i, exp_vld_i
  );
endinterface

// File: rtl/core_sim_monitor_rf.sv
// Shadow register file and expected-value table of the monitor.
// One write port each, one shared combinational read at the check index.
// Entry 0 (x0) is never written and always reads as zero / don't-care.
module core_sim_monitor_rf
  import core_sim_monitor_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            sh_clr,
  input  logic            sh_we,
  input  logic [AW-1:0]   sh_addr,
  input  logic [XLEN-1:0] sh_data,
  input  logic            ex_we,
  input  logic [AW-1:0]   ex_addr,
  input  logic [XLEN-1:0] ex_data,
  input  logic            ex_vld,
  input  logic [AW-1:0]   rd_idx,
  output logic [XLEN-1:0] rd_sh,
  output logic [XLEN-1:0] rd_exp,
  output logic            rd_vld
);
  localparam logic [AW-1:0] X0 = AW'(X0_IDX);

  logic [NREGS-1:0][XLEN-1:0] sh_q;
  logic [NREGS-1:0][XLEN-1:0] ex_q;
  logic [NREGS-1:0]           vld_q;

  // Shadow copy of the architectural registers, cleared at each run start
  always_ff @(posedge clk) begin
    if (!rstn || sh_clr)
      sh_q <= '0;
    else if (sh_we && sh_addr != X0)
      sh_q[sh_addr] <= sh_data;
  end

  // Expected-value table; survives run restarts, only reset clears it
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ex_q  <= '0;
      vld_q <= '0;
    end else if (ex_we && ex_addr != X0) begin
      ex_q[ex_addr]  <= ex_data;
      vld_q[ex_addr] <= ex_vld;
    end
  end

  assign rd_sh  = sh_q[rd_idx];
  assign rd_exp = ex_q[rd_idx];
  assign rd_vld = vld_q[rd_idx];

endmodule

// File: rtl/core_sim_monitor.sv
// Cycle-accurate self-checking monitor for riscv_core write-back.
// Shadows every register write during RUN, stops on the end-of-program
// write or the cycle budget, then sweeps x1..x(NREGS-1) against the
// programmed expected table one register per cycle and reports.
// Optional hang detector: define CORE_SIM_MONITOR_HANG_DET_EN.
module core_sim_monitor
  import core_sim_monitor_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NREGS       = 32,
  parameter int AW          = 5,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 1000,
  parameter int END_REG     = DEF_END_REG,
  parameter int END_VAL     = DEF_END_VAL,
  parameter int HANG_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  core_sim_monitor_if.slave bus,
  output logic              done_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic              timeout_o,
  output logic              hang_o,
  output logic [AW:0]       err_cnt_o,
  output logic [AW-1:0]     first_err_idx_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic [CNT_W-1:0]  wb_cnt_o
);
  localparam logic [AW-1:0]    X0       = AW'(X0_IDX);
  localparam logic [AW-1:0]    END_IDX  = AW'(END_REG);
  localparam logic [XLEN-1:0]  END_DAT  = XLEN'(END_VAL);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [AW-1:0]    LAST_IDX = AW'(NREGS - 1);
  localparam logic [AW-1:0]    IDX_ONE  = AW'(1);
  localparam logic [AW:0]      ERR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, wbc_q;
  logic [AW:0]      err_q;
  logic [AW-1:0]    ferr_q, idx_q;
  logic             to_q, hang_q, done_q, pass_q;

  logic             run, start_ok, wb_acc, end_hit, to_hit, hang_hit, mis;
  logic [XLEN-1:0]  rd_sh, rd_exp;
  logic             rd_vld;

  assign run      = (state_q == ST_RUN);
  assign start_ok = start_i && (state_q == ST_IDLE || state_q == ST_DONE);
  assign wb_acc   = run && bus.wb_we_i && (bus.wb_waddr_i != X0);
  assign end_hit  = wb_acc && (bus.wb_waddr_i == END_IDX) && (bus.wb_wdata_i == END_DAT);
  assign to_hit   = run && (cyc_q == TO_LAST);
  assign mis      = (state_q == ST_CHECK) && rd_vld && (rd_sh != rd_exp);

  core_sim_monitor_rf #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_rf (
    .clk     (clk),
    .rstn    (rstn),
    .sh_clr  (start_ok),
    .sh_we   (wb_acc),
    .sh_addr (bus.wb_waddr_i),
    .sh_data (bus.wb_wdata_i),
    .ex_we   (bus.exp_we_i && state_q == ST_IDLE),
    .ex_addr (bus.exp_addr_i),
    .ex_data (bus.exp_data_i),
    .ex_vld  (bus.exp_vld_i),
    .rd_idx  (idx_q),
    .rd_sh   (rd_sh),
    .rd_exp  (rd_exp),
    .rd_vld  (rd_vld)
  );

`ifdef CORE_SIM_MONITOR_HANG_DET_EN
  localparam logic [CNT_W-1:0] HANG_LAST = CNT_W'(HANG_CYCLES - 1);
  logic [CNT_W-1:0] idle_q;

  assign hang_hit = run && !wb_acc && (idle_q == HANG_LAST);

  // Idle counter since the last accepted write-back; flags a stalled core
  always_ff @(posedge clk) begin
    if (!rstn) begin
      idle_q <= '0;
      hang_q <= 1'b0;
    end else if (start_ok) begin
      idle_q <= '0;
      hang_q <= 1'b0;
    end else if (run) begin
      if (wb_acc)
        idle_q <= '0;
      else if (idle_q != '1)
        idle_q <= idle_q + CNT_ONE;
      // end trigger and timeout both outrank the hang detector
      if (hang_hit && !end_hit && !to_hit)
        hang_q <= 1'b1;
    end
  end
`else
  assign hang_hit = 1'b0;
  assign hang_q   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: run until end/timeout/hang, sweep, then park in DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_RUN;
      ST_RUN:   if (end_hit || to_hit || hang_hit) state_d = ST_CHECK;
      ST_CHECK: if (idx_q == LAST_IDX) state_d = ST_DONE;
      ST_DONE:  if (start_i) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Counters, check sweep and result registers
  always_ff @(posedge clk) begin
    if (!rstn || start_ok) begin
      cyc_q  <= '0;
      wbc_q  <= '0;
      err_q  <= '0;
      ferr_q <= '0;
      idx_q  <= '0;
      to_q   <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (cyc_q != '1) cyc_q <= cyc_q + CNT_ONE;
          if (wb_acc && wbc_q != '1) wbc_q <= wbc_q + CNT_ONE;
          if (to_hit && !end_hit) to_q <= 1'b1;
          idx_q <= IDX_ONE;  // sweep starts at x1
        end
        ST_CHECK: begin
          if (mis) begin
            if (err_q != '1) err_q <= err_q + ERR_ONE;
            if (err_q == '0) ferr_q <= idx_q;
          end
          idx_q <= idx_q + IDX_ONE;
        end
        ST_DONE: begin
          // err_q is final here, so the verdict is registered one cycle in
          done_q <= 1'b1;
          pass_q <= (err_q == '0) && !to_q && !hang_q;
        end
        default: ;
      endcase
    end
  end

  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign fail_o          = done_q && !pass_q;
  assign timeout_o       = to_q;
  assign hang_o          = hang_q;
  assign err_cnt_o       = err_q;
  assign first_err_idx_o = ferr_q;
  assign cycle_cnt_o     = cyc_q;
  assign wb_cnt_o        = wbc_q;

endmodule

// File: tb/tb_core_sim_monitor.sv
// Scoreboard bench for core_sim_monitor: a behavioural model tracks the
// architectural registers and run budget, pushes the expected report when
// a run ends, and a monitor compares it when done_o rises.
module tb_core_sim_monitor;
  localparam int XLEN = 32, NREGS = 32, AW = 5, CNT_W = 32;
  localparam int TIMEOUT = 1000, END_REG = 26, END_VAL = 1, HANG_CYCLES = 64;

  typedef struct {
    bit     to;
    bit     hang;
    int     err;
    int     first;
    int     cyc;
    int     wbn;
    longint done_at;
  } res_t;

  logic clk = 0, rstn = 0, start_i = 0;
  logic done_o, pass_o, fail_o, timeout_o, hang_o;
  logic [AW:0] err_cnt_o;
  logic [AW-1:0] first_err_idx_o;
  logic [CNT_W-1:0] cycle_cnt_o, wb_cnt_o;

  core_sim_monitor_if #(.AW(AW), .XLEN(XLEN)) bus ();

  core_sim_monitor #(
    .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT),
    .END_REG(END_REG), .END_VAL(END_VAL), .HANG_CYCLES(HANG_CYCLES)
  ) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .bus(bus),
    .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o),
    .hang_o(hang_o), .err_cnt_o(err_cnt_o), .first_err_idx_o(first_err_idx_o),
    .cycle_cnt_o(cycle_cnt_o), .wb_cnt_o(wb_cnt_o)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  res_t sb[$];

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_sh[NREGS];
  logic [XLEN-1:0] m_ex[NREGS];
  bit              m_vld[NREGS];
  bit m_run = 0;
  int m_cyc, m_wbn, m_idle;

  task automatic finish_run(bit to, bit hang);
    res_t r;
    r.to = to; r.hang = hang; r.err = 0; r.first = 0;
    for (int i = 1; i < NREGS; i++)
      if (m_vld[i] && m_sh[i] !== m_ex[i]) begin
        if (r.err == 0) r.first = i;
        r.err++;
      end
    r.cyc = m_cyc; r.wbn = m_wbn;
    r.done_at = cyc + NREGS;   // cyc here is the edge that ended the run
    sb.push_back(r);
    m_run = 0;
  endtask

  task automatic model_step(bit we, int a, logic [XLEN-1:0] d);
    bit acc = we && a != 0;
    m_cyc++;
    if (acc) begin m_sh[a] = d; m_wbn++; m_idle = 0; end
    else m_idle++;
    if (acc && a == END_REG && d == END_VAL) finish_run(0, 0);
    else if (m_cyc == TIMEOUT) finish_run(1, 0);
`ifdef CORE_SIM_MONITOR_HANG_DET_EN
    else if (m_idle == HANG_CYCLES) finish_run(0, 1);
`endif
  endtask

  // ---------------- stimulus tasks ----------------
  task automatic tick(); @(posedge clk); #1; endtask

  task automatic idle_bus();
    bus.wb_we_i = 0; bus.wb_waddr_i = '0; bus.wb_wdata_i = '0;
    bus.exp_we_i = 0; bus.exp_addr_i = '0; bus.exp_data_i = '0; bus.exp_vld_i = 0;
    start_i = 0;
  endtask

  task automatic do_reset();
    idle_bus(); rstn = 0; tick(); rstn = 1;
    for (int i = 0; i < NREGS; i++) begin m_sh[i] = '0; m_ex[i] = '0; m_vld[i] = 0; end
    m_run = 0;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_done"}, done_o, 0);     chk({tag, "_pass"}, pass_o, 0);
    chk({tag, "_fail"}, fail_o, 0);     chk({tag, "_to"}, timeout_o, 0);
    chk({tag, "_hang"}, hang_o, 0);     chk({tag, "_err"}, err_cnt_o, 0);
    chk({tag, "_first"}, first_err_idx_o, 0);
    chk({tag, "_cyc"}, cycle_cnt_o, 0); chk({tag, "_wbn"}, wb_cnt_o, 0);
  endtask

  task automatic prog(int a, logic [XLEN-1:0] d, bit v);
    bus.exp_we_i = 1; bus.exp_addr_i = AW'(a); bus.exp_data_i = d; bus.exp_vld_i = v;
    tick(); idle_bus();
    if (a != 0) begin m_ex[a] = d; m_vld[a] = v; end
  endtask

  task automatic start_run();
    start_i = 1; tick(); start_i = 0;
    for (int i = 0; i < NREGS; i++) m_sh[i] = '0;
    m_cyc = 0; m_wbn = 0; m_idle = 0; m_run = 1;
  endtask

  task automatic op(bit we, int a, logic [XLEN-1:0] d, bit st);
    bus.wb_we_i = we; bus.wb_waddr_i = AW'(a); bus.wb_wdata_i = d; start_i = st;
    tick(); idle_bus();
    if (m_run) model_step(we, a, d);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      chk("done_wait_expired", sb.size(), 0);
      sb.delete();
    end
  endtask

  // ---------------- monitor ----------------
  bit done_prev = 0;
  always @(negedge clk) begin
    res_t r;
    if (rstn && done_o && !done_prev) begin
      if (sb.size() == 0) chk("unexpected_done", done_o, 0);
      else begin
        r = sb.pop_front();
        chk("done_latency", cyc, r.done_at);
        chk("pass", pass_o, (r.err == 0 && !r.to && !r.hang));
        chk("fail", fail_o, !(r.err == 0 && !r.to && !r.hang));
        chk("timeout", timeout_o, r.to);
        chk("hang", hang_o, r.hang);
        chk("err_cnt", err_cnt_o, r.err);
        chk("first_err", first_err_idx_o, r.first);
        chk("cycle_cnt", cycle_cnt_o, r.cyc);
        chk("wb_cnt", wb_cnt_o, r.wbn);
      end
    end
    done_prev = done_o;
  end

  // ---------------- test sequence ----------------
  initial begin
    idle_bus();
    @(posedge clk); #1;
    do_reset();
    check_zero("reset");

    // 1: simple pass
    prog(1, 5, 1); prog(2, 7, 1); prog(3, 12, 1);
    start_run();
    op(1, 1, 5, 0); op(1, 2, 7, 0); op(1, 3, 12, 0); op(1, END_REG, END_VAL, 0);
    wait_done();

    // 2: single mismatch on x3
    do_reset();
    prog(3, 12, 1);
    start_run();
    op(1, 3, 11, 0); op(1, END_REG, END_VAL, 0);
    wait_done();

    // 3: no end marker -> timeout, fails despite no mismatches
    do_reset();
    start_run();
    for (int i = 0; i < 2 * TIMEOUT && m_run; i++) op(1, 0, 9, 0);
    wait_done();

    // 4: end marker on the timeout cycle; restart from DONE clears results
    start_run();
    chk("restart_done", done_o, 0);
    chk("restart_to", timeout_o, 0);
    chk("restart_cyc", cycle_cnt_o, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) op(1, 0, 9, 0);
    op(1, END_REG, END_VAL, 0);
    wait_done();

    // 5: reset mid-run clears everything including expected-valid bits
    prog(4, 77, 1);   // DONE state: must be ignored
    start_run();
    op(1, 5, 3, 0); op(1, 6, 4, 0);
    do_reset();
    check_zero("midrst");
    start_run();
    for (int i = 1; i < 20; i++) op(1, i, $urandom, 0);
    op(1, END_REG, END_VAL, 0);
    wait_done();

    // 6: write-backs stop -> hang (if built) or timeout
    do_reset();
    prog(7, 42, 1);
    start_run();
    op(1, 7, 42, 0); op(1, 8, 1, 0);
    for (int i = 0; i < 2 * TIMEOUT && m_run; i++) op(0, $urandom_range(0, 31), 0, 0);
    wait_done();

    // randomized runs
    for (int k = 0; k < 10; k++) begin
      int n;
      do_reset();
      for (int i = 0; i < NREGS; i++)
        if ($urandom_range(0, 1)) prog(i, $urandom_range(0, 3), $urandom_range(0, 1));
      start_run();
      n = $urandom_range(5, 80);
      for (int i = 0; i < n && m_run; i++)
        op($urandom_range(0, 3) != 0, $urandom_range(0, NREGS - 1),
           $urandom_range(0, 3), $urandom_range(0, 7) == 0);
      if (m_run) op(1, END_REG, END_VAL, 0);
      wait_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
